// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage with IF/ID pipeline register. Holds the
//            PC, issues one instruction-memory request at a time over a
//            valid/ready request channel, consumes exactly one response per
//            accepted request, and honours redirect / stall / flush.
// Options  : FETCH_MISALIGN_CHECK_EN - adds FetchMisalignF; a misaligned
//            redirect target leaves the PC untouched and raises the flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        RedirectF,
  input  logic [63:0] PCTargetF,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [63:0] ImemReqAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic [31:0] InstrD,
  output logic [63:0] PCD,
  output logic [63:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        FetchMisalignF
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic [63:0] redir_pc;
  logic [31:0] hold_instr;
  logic        take_redirect;
  logic        misalign_hit;
  logic        deliver;
  logic [31:0] deliver_instr;

  assign pc_plus4     = pc + 64'd4;
  assign ImemReqAddr  = pc;
  // Request is only presented while idle in REQ and never during reset.
  assign ImemReqValid = rst && (state == S_REQ);

  // Decode whether a redirect actually moves the PC, and to where.
  always_comb begin
    redir_pc      = PCTargetF & ~64'h3;
    take_redirect = RedirectF;
    misalign_hit  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_pc      = PCTargetF;
    misalign_hit  = RedirectF && (PCTargetF[1:0] != 2'b00);
    take_redirect = RedirectF && (PCTargetF[1:0] == 2'b00);
`endif
  end

  // A new instruction leaves the fetch FSM this cycle (fresh or held).
  always_comb begin
    deliver = !take_redirect && !StallF &&
              (((state == S_WAIT) && ImemRspValid) || (state == S_HOLD));
    deliver_instr = (state == S_HOLD) ? hold_instr : ImemRspData;
  end

  // Fetch FSM: PC sequencing and outstanding-request bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_instr <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (take_redirect) pc <= redir_pc;
          if (ImemReqReady) state <= take_redirect ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (take_redirect) begin
            pc    <= redir_pc;
            state <= ImemRspValid ? S_REQ : S_DROP;
          end else if (ImemRspValid) begin
            if (!StallF) begin
              pc    <= pc_plus4;
              state <= S_REQ;
            end else begin
              hold_instr <= ImemRspData;
              state      <= S_HOLD;
            end
          end
        end
        S_DROP: begin
          // The response in flight belongs to a stale PC; swallow it.
          if (take_redirect) pc <= redir_pc;
          if (ImemRspValid) state <= S_REQ;
        end
        S_HOLD: begin
          if (take_redirect) begin
            pc    <= redir_pc;
            state <= S_REQ;
          end else if (!StallF) begin
            pc    <= pc_plus4;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // IF/ID register: bubble > hold > load > bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (RedirectF || FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallF) begin
      InstrD <= InstrD;
      ValidD <= ValidD;
    end else if (deliver) begin
      InstrD   <= deliver_instr;
      PCD      <= pc;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // One-cycle registered flag for a rejected misaligned redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) FetchMisalignF <= 1'b0;
    else      FetchMisalignF <= misalign_hit;
  end
`else
  logic unused_misalign;
  assign unused_misalign = misalign_hit;
`endif

endmodule

`default_nettype wire
